// File: rtl/board_vga_renderer.sv
// Board display end: 640x480@60 VGA timing from a 50 MHz clock, drawing a 4x4 game grid
// from a shadow copy of the board state that is latched once per frame during vertical blanking.
module board_vga_renderer #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned CELL   = 96,
  parameter int unsigned X0     = 128,
  parameter int unsigned Y0     = 48,
  parameter int unsigned LINE_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] cells_i,
  input  logic [3:0]  cursor_i,
  input  logic        cursor_en_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vgaclk_o,
  output logic        blank_n_o,
  output logic        frame_start_o
);
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned OW    = $clog2(CELL);
  localparam int unsigned BOARD = 4 * CELL + LINE_W;

  logic          vgaclk_q, pix_en, h_wrap;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [2:0]    col_q, col_d, row_q, row_d;
  logic [63:0]   sh_cells_q;
  logic [3:0]    sh_cursor_q;
  logic          sh_cursor_en_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d, frame_start_q;
  logic          visible, in_board, on_grid, cur_hit, in_fill;
  logic [3:0]    cell_idx, code;

  assign pix_en = vgaclk_q;

  function automatic logic in_band(logic [OW-1:0] o);
    return (o >= OW'(LINE_W) && o < OW'(2 * LINE_W)) ||
           (o >= OW'(CELL - 2 * LINE_W) && o < OW'(CELL - LINE_W));
  endfunction

  // Offset counters restart where the board begins and step to the next cell every CELL pixels.
  always_comb begin
    h_wrap   = (hcount_q == HW'(H_TOT - 1));
    hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (h_wrap) vcount_d = (vcount_q == VW'(V_TOT - 1)) ? '0 : vcount_q + VW'(1);

    ox_d  = ox_q + OW'(1);
    col_d = col_q;
    if (hcount_d == HW'(X0)) begin
      ox_d  = '0;
      col_d = '0;
    end else if (ox_q == OW'(CELL - 1)) begin
      ox_d  = '0;
      col_d = col_q + 3'd1;
    end

    oy_d  = oy_q;
    row_d = row_q;
    if (h_wrap) begin
      if (vcount_d == VW'(Y0)) begin
        oy_d  = '0;
        row_d = '0;
      end else if (oy_q == OW'(CELL - 1)) begin
        oy_d  = '0;
        row_d = row_q + 3'd1;
      end else begin
        oy_d  = oy_q + OW'(1);
      end
    end
  end

  always_comb begin
    visible   = (hcount_q < HW'(H_VIS)) && (vcount_q < VW'(V_VIS));
    in_board  = (hcount_q >= HW'(X0)) && (hcount_q < HW'(X0 + BOARD)) &&
                (vcount_q >= VW'(Y0)) && (vcount_q < VW'(Y0 + BOARD));
    on_grid   = (ox_q < OW'(LINE_W)) || (oy_q < OW'(LINE_W)) || (col_q == 3'd4) || (row_q == 3'd4);
    cell_idx  = {row_q[1:0], col_q[1:0]};
    code      = sh_cells_q[{cell_idx, 2'b00} +: 4];
    cur_hit   = sh_cursor_en_q && (cell_idx == sh_cursor_q) && (in_band(ox_q) || in_band(oy_q));
    in_fill   = (ox_q >= OW'(4 * LINE_W)) && (ox_q < OW'(CELL - 4 * LINE_W)) &&
                (oy_q >= OW'(4 * LINE_W)) && (oy_q < OW'(CELL - 4 * LINE_W));
    hsync_d   = !((hcount_q >= HW'(H_VIS + H_FP)) && (hcount_q < HW'(H_VIS + H_FP + H_SYNC)));
    vsync_d   = !((vcount_q >= VW'(V_VIS + V_FP)) && (vcount_q < VW'(V_VIS + V_FP + V_SYNC)));
    blank_n_d = visible;
    if (!visible || !in_board)     rgb_d = 24'h000000;
    else if (on_grid)              rgb_d = 24'hFFFFFF;
    else if (cur_hit)              rgb_d = 24'hFFFF00;
    else if (in_fill && code == 4'd1) rgb_d = 24'hFF0000;
    else if (in_fill && code == 4'd2) rgb_d = 24'h0000FF;
    else if (in_fill && code != 4'd0) rgb_d = 24'hFF00FF;
    else                           rgb_d = 24'h303030;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vgaclk_q       <= 1'b0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      ox_q           <= '0;
      oy_q           <= '0;
      col_q          <= '0;
      row_q          <= '0;
      sh_cells_q     <= '0;
      sh_cursor_q    <= '0;
      sh_cursor_en_q <= 1'b0;
      rgb_q          <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      blank_n_q      <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      vgaclk_q      <= !vgaclk_q;
      frame_start_q <= 1'b0;
      if (pix_en) begin
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        ox_q          <= ox_d;
        oy_q          <= oy_d;
        col_q         <= col_d;
        row_q         <= row_d;
        rgb_q         <= rgb_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        blank_n_q     <= blank_n_d;
        frame_start_q <= (hcount_q == '0) && (vcount_q == '0);
        // Board state is only sampled in vertical blanking so a frame never tears.
        if ((hcount_q == '0) && (vcount_q == VW'(V_VIS))) begin
          sh_cells_q     <= cells_i;
          sh_cursor_q    <= cursor_i;
          sh_cursor_en_q <= cursor_en_i;
        end
      end
    end
  end

  assign {r_o, g_o, b_o} = rgb_q;
  assign hsync_o         = hsync_q;
  assign vsync_o         = vsync_q;
  assign vgaclk_o        = vgaclk_q;
  assign blank_n_o       = blank_n_q;
  assign frame_start_o   = frame_start_q;

endmodule

// File: tb/tb_board_vga_renderer.sv
// Bench for board_vga_renderer on a shrunken screen/board so whole frames fit a short run;
// a pixel-level reference model (plain div/mod geometry) is compared every clock.
module tb_board_vga_renderer;
  localparam int HV = 60, HF = 4, HS = 6, HB = 2;
  localparam int VV = 54, VF = 2, VS = 2, VB = 2;
  localparam int CELL = 12, X0 = 6, Y0 = 2, LW = 1;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, FRAME = HT * VT;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] cells = '0;
  logic [3:0]  cursor = '0;
  logic        cursor_en = 1'b0;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, vgaclk, blank_n, frame_start;
  int          n_cmp = 0, n_fail = 0;

  // Reference model state
  int          k, out_h, out_v;
  logic [23:0] e_rgb;
  logic        e_hs, e_vs, e_bn, e_fs, e_vgaclk;
  int          sh_code[16];
  int          sh_cur;
  bit          sh_en;

  // Known-answer pixels for the fixed board: cell0=1, cell5=7, cell15=2, cursor on cell6
  int          sp_x[15] = '{6, 12, 9, 14, 48, 24, 31, 40, 41, 36, 54, 55, 20, 3, 62};
  int          sp_y[15] = '{2, 8, 8, 8, 44, 20, 20, 20, 20, 20, 20, 20, 50, 20, 10};
  logic [23:0] sp_c[15] = '{24'hFFFFFF, 24'hFF0000, 24'h303030, 24'h303030, 24'h0000FF,
                            24'hFF00FF, 24'hFFFF00, 24'hFFFF00, 24'h303030, 24'h303030,
                            24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};

  always #5 clk = ~clk;

  board_vga_renderer #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CELL(CELL), .X0(X0), .Y0(Y0), .LINE_W(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cells_i(cells), .cursor_i(cursor), .cursor_en_i(cursor_en),
    .r_o(r), .g_o(g), .b_o(b), .hsync_o(hsync), .vsync_o(vsync), .vgaclk_o(vgaclk),
    .blank_n_o(blank_n), .frame_start_o(frame_start)
  );

  function automatic bit in_band(int o);
    return (o >= LW && o < 2 * LW) || (o >= CELL - 2 * LW && o < CELL - LW);
  endfunction

  function automatic logic [23:0] ref_colour(int x, int y);
    int bx, by, ox, oy, col, row, code;
    bit fill;
    if (x >= HV || y >= VV) return 24'h000000;
    bx = x - X0;
    by = y - Y0;
    if (bx < 0 || by < 0 || bx >= 4 * CELL + LW || by >= 4 * CELL + LW) return 24'h000000;
    col = bx / CELL; row = by / CELL; ox = bx % CELL; oy = by % CELL;
    if (ox < LW || oy < LW || col == 4 || row == 4) return 24'hFFFFFF;
    if (sh_en && row * 4 + col == sh_cur && (in_band(ox) || in_band(oy))) return 24'hFFFF00;
    code = sh_code[row * 4 + col];
    fill = ox >= 4 * LW && ox < CELL - 4 * LW && oy >= 4 * LW && oy < CELL - 4 * LW;
    if (fill && code == 1) return 24'hFF0000;
    if (fill && code == 2) return 24'h0000FF;
    if (fill && code >= 3) return 24'hFF00FF;
    return 24'h303030;
  endfunction

  // One system clock: k counts edges since release; every even edge shows pixel k/2-1.
  task automatic tick();
    int n;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; out_h = -1; out_v = -1;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_fs = 1'b0; e_vgaclk = 1'b0;
      for (int i = 0; i < 16; i++) sh_code[i] = 0;
      sh_cur = 0; sh_en = 1'b0;
    end else begin
      k++;
      e_vgaclk = (k % 2 == 1);
      e_fs = 1'b0;
      if (k % 2 == 0) begin
        n = (k / 2 - 1) % FRAME;
        out_h = n % HT;
        out_v = n / HT;
        e_bn  = out_h < HV && out_v < VV;
        e_hs  = !(out_h >= HV + HF && out_h < HV + HF + HS);
        e_vs  = !(out_v >= VV + VF && out_v < VV + VF + VS);
        e_rgb = ref_colour(out_h, out_v);
        e_fs  = (n == 0);
        if (out_h == 0 && out_v == VV) begin
          for (int i = 0; i < 16; i++) sh_code[i] = int'(cells[i * 4 +: 4]);
          sh_cur = int'(cursor);
          sh_en  = cursor_en;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 16; i++)
      cells[i * 4 +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(3, 15))
                                                      : 4'($urandom_range(0, 2));
    cursor    = 4'($urandom_range(0, 15));
    cursor_en = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rand_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !== {5'b01100, 24'h0}) begin
        n_fail++;
        $display("FAIL reset_hold clk%0d: got %b/%h%h%h want 01100/000000", i,
                 {vgaclk, hsync, vsync, blank_n, frame_start}, r, g, b);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !== {5'b11100, 24'h0}) begin
      n_fail++;
      $display("FAIL release_clk1: got %b/%h%h%h want 11100/000000",
               {vgaclk, hsync, vsync, blank_n, frame_start}, r, g, b);
    end
    tick();
    n_cmp++;
    if ({vgaclk, frame_start} !== 2'b01) begin
      n_fail++;
      $display("FAIL first_pix_en: vgaclk,frame_start got %b want 01", {vgaclk, frame_start});
    end
    tick();
    n_cmp++;
    if ({vgaclk, frame_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL fs_width: vgaclk,frame_start got %b want 10", {vgaclk, frame_start});
    end
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, start_k;
    bit seen = 1'b0;
    cells = '0; cells[3:0] = 4'd1; cells[23:20] = 4'd7; cells[63:60] = 4'd2;
    cursor = 4'd6; cursor_en = 1'b1;
    start_k = 2;
    for (int i = 0; i < 2 * FRAME + 8 && !seen; i++) begin
      tick();
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !==
          {e_vgaclk, e_hs, e_vs, e_bn, e_fs, e_rgb}) begin
        n_fail++;
        $display("FAIL timing k=%0d px(%0d,%0d): got %b/%h%h%h want %b/%h", k, out_h, out_v,
                 {vgaclk, hsync, vsync, blank_n, frame_start}, r, g, b,
                 {e_vgaclk, e_hs, e_vs, e_bn, e_fs}, e_rgb);
      end
      if (frame_start) seen = 1'b1;
      else begin
        hs_low += int'(!hsync);
        vs_low += int'(!vsync);
      end
    end
    n_cmp++;
    if (!seen || k - start_k != 2 * FRAME) begin
      n_fail++;
      $display("FAIL frame_len: got %0d clks (seen=%0d) want %0d", k - start_k, seen, 2 * FRAME);
    end
    n_cmp++;
    if (hs_low != 2 * HS * VT) begin
      n_fail++;
      $display("FAIL hsync_low_clks: got %0d want %0d", hs_low, 2 * HS * VT);
    end
    n_cmp++;
    if (vs_low != 2 * VS * HT) begin
      n_fail++;
      $display("FAIL vsync_low_clks: got %0d want %0d", vs_low, 2 * VS * HT);
    end
  endtask

  task automatic test_spots();
    bit hit[15];
    for (int j = 0; j < 15; j++) hit[j] = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (k % 2 == 0) begin
        for (int j = 0; j < 15; j++) begin
          if (!hit[j] && out_h == sp_x[j] && out_v == sp_y[j]) begin
            hit[j] = 1'b1;
            n_cmp++;
            if ({r, g, b} !== sp_c[j] || blank_n !== (sp_x[j] < HV)) begin
              n_fail++;
              $display("FAIL spot(%0d,%0d): got %h%h%h bn=%b want %h bn=%b", sp_x[j], sp_y[j],
                       r, g, b, blank_n, sp_c[j], sp_x[j] < HV);
            end
          end
        end
      end
    end
    for (int j = 0; j < 15; j++) begin
      n_cmp++;
      if (!hit[j]) begin
        n_fail++;
        $display("FAIL spot_reached(%0d,%0d): got 0 want 1", sp_x[j], sp_y[j]);
      end
    end
  endtask

  task automatic test_random_board();
    rand_inputs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !==
          {e_vgaclk, e_hs, e_vs, e_bn, e_fs, e_rgb}) begin
        n_fail++;
        $display("FAIL random_board px(%0d,%0d): got %h%h%h want %h", out_h, out_v, r, g, b,
                 e_rgb);
      end
    end
  endtask

  task automatic test_no_tear();
    int i = 0;
    while (out_v != VV / 2 && i < 2 * FRAME) begin
      tick();
      i++;
    end
    rand_inputs();
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (c % 500 == 0) rand_inputs();
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !==
          {e_vgaclk, e_hs, e_vs, e_bn, e_fs, e_rgb}) begin
        n_fail++;
        $display("FAIL no_tear px(%0d,%0d): got %h%h%h want %h", out_h, out_v, r, g, b, e_rgb);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int fs_cnt = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !== {5'b01100, 24'h0}) begin
        n_fail++;
        $display("FAIL mid_reset clk%0d: got %b/%h%h%h want 01100/000000", i,
                 {vgaclk, hsync, vsync, blank_n, frame_start}, r, g, b);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6 * HT; i++) begin
      tick();
      fs_cnt += int'(frame_start);
      n_cmp++;
      if ({vgaclk, hsync, vsync, blank_n, frame_start, r, g, b} !==
          {e_vgaclk, e_hs, e_vs, e_bn, e_fs, e_rgb}) begin
        n_fail++;
        $display("FAIL restart k=%0d px(%0d,%0d): got %b/%h%h%h want %b/%h", k, out_h, out_v,
                 {vgaclk, hsync, vsync, blank_n, frame_start}, r, g, b,
                 {e_vgaclk, e_hs, e_vs, e_bn, e_fs}, e_rgb);
      end
    end
    n_cmp++;
    if (fs_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_fs_count: got %0d want 1", fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_spots();
    test_random_board();
    test_no_tear();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
